// File: rtl/adder_operand_pairer_if.sv
// Purpose: operand A/B ready-valid channels plus paired output bus of the adder operand pairer.
// Latency: none (wiring only).
// Backpressure: o_a_ready/o_b_ready throttle the operand producers; the pair output has none.
// Ports: i_a_* / i_b_* operand channels, i_en issue enable, i_flush clear,
//        o_valid/o_data_bus registered pair, o_a_count/o_b_count occupancy.
interface adder_operand_pairer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1);

  logic                    i_a_valid;
  logic [DATA_WIDTH-1:0]   i_a_data;
  logic                    o_a_ready;
  logic                    i_b_valid;
  logic [DATA_WIDTH-1:0]   i_b_data;
  logic                    o_b_ready;
  logic                    i_en;
  logic                    i_flush;
  logic [1:0]              o_valid;
  logic [2*DATA_WIDTH-1:0] o_data_bus;
  logic [CNT_WIDTH-1:0]    o_a_count;
  logic [CNT_WIDTH-1:0]    o_b_count;

  // Pairer side.
  modport slave (
    input  i_a_valid, i_a_data, i_b_valid, i_b_data, i_en, i_flush,
    output o_a_ready, o_b_ready, o_valid, o_data_bus, o_a_count, o_b_count
  );

  // Producer / consumer side.
  modport master (
    output i_a_valid, i_a_data, i_b_valid, i_b_data, i_en, i_flush,
    input  o_a_ready, o_b_ready, o_valid, o_data_bus, o_a_count, o_b_count
  );
endinterface

// File: rtl/adder_operand_pairer.sv
// Purpose: buffer operands A and B in independent FIFOs and issue them as one registered pair.
// Latency: 2 edges from push into empty FIFOs to o_valid=2'b11.
// Backpressure: each side's ready drops when its FIFO is full; the pair output is never stalled.
// Ports: clk, rst (sync, active-high), bus (adder_operand_pairer_if.slave).

// Generic single-clock FIFO: registered count, no pass-through when full.
// Latency: head visible the cycle after the push edge.
// Backpressure: push_rdy = not full; caller must only pop when count != 0.
module aop_fifo #(
  parameter  int W     = 16,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push_vld,
  input  logic [W-1:0]     push_dat,
  output logic             push_rdy,
  input  logic             pop,
  output logic [W-1:0]     head_dat,
  output logic [CNT_W-1:0] count
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop_ok;

  assign push_rdy = (count_q != FULL);
  // A flush drops the offered push even though ready was high.
  assign push     = push_vld & push_rdy & ~clr;
  assign pop_ok   = pop & ~clr;
  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)   wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_dat;
  end
endmodule

module adder_operand_pairer #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  adder_operand_pairer_if.slave   bus
);
  localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0]   a_head, b_head;
  logic [CNT_WIDTH-1:0]    a_cnt, b_cnt;
  logic                    issue;
  logic [1:0]              valid_q, valid_d;
  logic [2*DATA_WIDTH-1:0] data_q, data_d;

  // Issue looks only at registered counts, so a same-cycle push never pairs.
  assign issue = bus.i_en & (a_cnt != '0) & (b_cnt != '0) & ~bus.i_flush;

  aop_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.i_flush),
    .push_vld (bus.i_a_valid),
    .push_dat (bus.i_a_data),
    .push_rdy (bus.o_a_ready),
    .pop      (issue),
    .head_dat (a_head),
    .count    (a_cnt)
  );

  aop_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.i_flush),
    .push_vld (bus.i_b_valid),
    .push_dat (bus.i_b_data),
    .push_rdy (bus.o_b_ready),
    .pop      (issue),
    .head_dat (b_head),
    .count    (b_cnt)
  );

  // Idle output is all-zero so the adder sees its dummy operands.
  always_comb begin
    valid_d = 2'b00;
    data_d  = '0;
    if (issue) begin
      valid_d = 2'b11;
      data_d  = {a_head, b_head};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 2'b00;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign bus.o_valid    = valid_q;
  assign bus.o_data_bus = data_q;
  assign bus.o_a_count  = a_cnt;
  assign bus.o_b_count  = b_cnt;
endmodule

// File: tb/tb_adder_operand_pairer.sv
// Purpose: randomized + directed scoreboard bench for adder_operand_pairer.
// Latency: expectations are one entry per clock edge, checked 1 time unit after the edge.
// Backpressure: the operand queue model refuses pushes when a side holds FIFO_DEPTH entries.
module tb_adder_operand_pairer;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  typedef struct {
    logic [1:0]      vld;
    logic [2*DW-1:0] dat;
    int              a_cnt;
    int              b_cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adder_operand_pairer_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

  adder_operand_pairer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t          exp_q [$];
  logic [DW-1:0] qa [$];
  logic [DW-1:0] qb [$];
  int            checks = 0;
  int            passes = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
  endtask

  // Monitor: every edge the DUT presents a new output, compare with the oldest expectation.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("o_valid",    64'(bus.o_valid),    64'(e.vld));
      chk("o_data_bus", 64'(bus.o_data_bus), 64'(e.dat));
      chk("o_a_count",  64'(bus.o_a_count),  64'(e.a_cnt));
      chk("o_b_count",  64'(bus.o_b_count),  64'(e.b_cnt));
      chk("o_a_ready",  64'(bus.o_a_ready),  64'(e.a_cnt != DEPTH));
      chk("o_b_ready",  64'(bus.o_b_ready),  64'(e.b_cnt != DEPTH));
    end
  end

  // Drive one cycle and predict the effect of the coming edge from queue arithmetic.
  task automatic cyc(input logic r, input logic f, input logic en,
                     input logic av, input logic [DW-1:0] ad,
                     input logic bv, input logic [DW-1:0] bd);
    exp_t          e;
    logic [DW-1:0] ha, hb;
    bit            pair_now, take_a, take_b;
    rst           = r;
    bus.i_flush   = f;
    bus.i_en      = en;
    bus.i_a_valid = av;
    bus.i_a_data  = ad;
    bus.i_b_valid = bv;
    bus.i_b_data  = bd;
    e.vld = 2'b00;
    e.dat = '0;
    if (r || f) begin
      qa.delete();
      qb.delete();
    end else begin
      pair_now = en && qa.size() > 0 && qb.size() > 0;
      take_a   = av && qa.size() < DEPTH;
      take_b   = bv && qb.size() < DEPTH;
      if (pair_now) begin
        ha    = qa.pop_front();
        hb    = qb.pop_front();
        e.vld = 2'b11;
        e.dat = {ha, hb};
      end
      if (take_a) qa.push_back(ad);
      if (take_b) qb.push_back(bd);
    end
    e.a_cnt = qa.size();
    e.b_cnt = qb.size();
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic en, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, en, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    // 1: reset held two cycles, then idle.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    idle(1'b1, 2);

    // 2: aligned streams, four back-to-back pairs.
    for (int i = 1; i <= 4; i++)
      cyc(1'b0, 1'b0, 1'b1, 1'b1, DW'(i), 1'b1, DW'(i * 16));
    idle(1'b1, 3);

    // 3: A runs ahead to full, fifth A refused, then B catches up.
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'b0, 1'b1, 1'b1, DW'(16'h0A + i), 1'b0, '0);
    for (int i = 1; i <= 4; i++)
      cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, DW'(i));
    idle(1'b1, 3);

    // 4: enable gating with two entries per side.
    for (int i = 0; i < 2; i++)
      cyc(1'b0, 1'b0, 1'b0, 1'b1, DW'(16'h100 + i), 1'b1, DW'(16'h200 + i));
    idle(1'b0, 3);
    idle(1'b1, 3);

    // 5: flush against a push with counts 3/1.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0301, 1'b1, 16'h0401);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0302, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0303, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h0304, 1'b0, '0);
    idle(1'b1, 3);

    // 6: reset in a cycle where a pair would issue.
    for (int i = 0; i < 2; i++)
      cyc(1'b0, 1'b0, 1'b0, 1'b1, DW'(16'h500 + i), 1'b1, DW'(16'h600 + i));
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'h0555, 1'b1, 16'h0666);
    idle(1'b1, 3);

    // Random traffic with skew, gating, and rare flush/reset.
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 49) == 0),
          ($urandom_range(0, 9) < 8),
          ($urandom_range(0, 9) < 6), DW'($urandom),
          ($urandom_range(0, 9) < 5), DW'($urandom));
    idle(1'b1, 8);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/adder_operand_pairer.md
Name: adder_operand_pairer

Overview:
- Upstream feeder for the sequential two-input adder stage.
- Buffers operand A and operand B, which arrive independently on two ready/valid channels, each in its own FIFO.
- When both heads are present and enabled, pops one of each and issues them as one registered pair: packed 2*DATA_WIDTH bus plus 2-bit valid, directly consumable by the adder.
- The adder has no backpressure, so this block is the point where operand skew is absorbed.

Parameters:
DATA_WIDTH, 16, width of each operand.
FIFO_DEPTH, 4, entries per operand FIFO; power of two, >= 2.
CNT_WIDTH, $clog2(FIFO_DEPTH+1), width of occupancy counters (derived, not overridden).

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
i_a_valid  input  1  operand A offered.
i_a_data  input  DATA_WIDTH  operand A value.
o_a_ready  output  1  A FIFO can accept (not full).
i_b_valid  input  1  operand B offered.
i_b_data  input  DATA_WIDTH  operand B value.
o_b_ready  output  1  B FIFO can accept (not full).
i_en  input  1  issue enable; also the downstream adder enable.
i_flush  input  1  synchronous clear of both FIFOs and the output register.
o_valid  output  2  pair valid; bit1 = A, bit0 = B; always 2'b11 or 2'b00.
o_data_bus  output  2*DATA_WIDTH  {A, B}; A in [DATA_WIDTH+:DATA_WIDTH], B in [DATA_WIDTH-1:0].
o_a_count  output  CNT_WIDTH  A FIFO occupancy.
o_b_count  output  CNT_WIDTH  B FIFO occupancy.

Behaviour:
- Reset (rst=1 at clk edge):
  - Both FIFOs empty; pointers 0; counts 0.
  - o_valid=2'b00, o_data_bus=0.
  - o_a_ready=o_b_ready=1 from the first cycle after reset.
  - Reset mid-operation discards all buffered operands; no pair is issued in that cycle.
- Priority: rst > i_flush > normal operation.
- i_flush has the same effect as reset on FIFOs and outputs. Pushes offered in the flush cycle are dropped, even though ready was high.
- Push A: i_a_valid & o_a_ready at the edge writes i_a_data at the A write pointer. B is identical and fully independent.
- Ready:
  - o_x_ready = (count_x != FIFO_DEPTH), combinational from the registered count.
  - No same-cycle pass-through when full: a full FIFO refuses a push even if a pop happens in that cycle.
- Issue condition: issue = i_en & (count_a != 0) & (count_b != 0), evaluated on registered counts.
- When issue is true at the edge:
  - Both FIFOs pop once.
  - o_data_bus <= {head_a, head_b}; o_valid <= 2'b11.
- Otherwise: o_valid <= 2'b00 and o_data_bus <= 0, so idle output is zero, matching the adder's dummy data.
- Latency: operands pushed at edge k (both FIFOs previously empty) give o_valid=2'b11 in the cycle after edge k+1. Minimum latency is 2 edges.
- Throughput: one pair per cycle sustained when both channels push every cycle and i_en=1.
- Simultaneous push and pop on a side: count is unchanged, both pointers advance. Order is FIFO-exact per side.
- Pointer wrap: pointers are log2(FIFO_DEPTH) bits and wrap naturally. Counts carry the full/empty distinction.
- Skew: a side that runs ahead fills up to FIFO_DEPTH and then stalls via ready. The other side is unaffected.
- i_en=0:
  - No pops; output registers are cleared to 0/2'b00.
  - Pushes continue until full.
- No arithmetic and no width change on data; operands pass through bit-exact.

Test Plan:
1. Reset then idle: rst high 2 cycles, release -> o_valid=00, o_data_bus=0, counts 0, both ready=1.
2. Aligned streams, DATA_WIDTH=16: push A=0x0001..0x0004 and B=0x0010..0x0040 on the same cycles, i_en=1 -> four consecutive pairs {0x0001,0x0010}..{0x0004,0x0040}, first one 2 edges after the first push, o_valid=11 each.
3. Skew and full: push A 0x0A,0x0B,0x0C,0x0D with no B -> count_a=4, o_a_ready=0, a 5th A is refused and not stored. Then push B 0x01..0x04 -> pairs {0x0A,0x01}..{0x0D,0x04} in order. o_a_ready returns to 1 the cycle after the first pop.
4. i_en gating: both FIFOs hold 2 entries, i_en=0 for 3 cycles -> o_valid=00, counts stay 2. i_en=1 -> two pairs on consecutive cycles.
5. Flush versus push: counts 3/1 with i_flush=1 and i_a_valid=1 in the same cycle -> next cycle counts 0/0, o_valid=00, and no pair from the old data is ever issued.
6. Reset mid-stream: rst asserted in a cycle where issue would fire -> o_valid=00 on the next cycle, counts 0, previously buffered operands never appear.
